// File: rtl/spi_packet_master.sv
// SPI mode-0 master: shifts a PKT_BYTES command packet under one chip-select and captures the reply bytes.
// Latency: cs_n low for 2H + 16H*PKT_BYTES + GAP_CYCLES*(PKT_BYTES-1) cycles (H = cdiv+1), rsp_valid the cycle after.
// Backpressure: pkt_ready is high only in IDLE; offers while busy wait, abort drops the packet in flight.
module spi_packet_master #(
    parameter int PKT_BYTES  = 12,
    parameter int DIV_W      = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic [8*PKT_BYTES-1:0] pkt_in,
    input  logic                   pkt_valid,
    output logic                   pkt_ready,
    input  logic [DIV_W-1:0]       cdiv,
    input  logic                   mlb,
    input  logic                   abort,
    input  logic                   miso,
    output logic                   sck,
    output logic                   cs_n,
    output logic                   mosi,
    output logic [8*PKT_BYTES-1:0] rsp_data,
    output logic                   rsp_valid,
    output logic                   aborted,
    output logic                   busy
);
    localparam int PW = 8 * PKT_BYTES;
    localparam int BW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(PKT_BYTES - 1);
    localparam logic [GW-1:0] LAST_GAP  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_HOLD,
        ST_DONE,
        ST_ABORT
    } state_t;

    state_t           state;
    logic [PW-1:0]    pkt_sh;     // remaining tx bytes, current byte in the top slot
    logic [7:0]       tx_byte;    // current tx byte, shifted towards the active end
    logic [7:0]       rx_byte;
    logic [DIV_W-1:0] cdiv_r;
    logic             mlb_r;
    logic [DIV_W-1:0] cnt;        // half-period / setup / hold counter
    logic [2:0]       bit_cnt;
    logic [BW-1:0]    byte_idx;
    logic [GW-1:0]    gap_cnt;

    logic [PW-1:0]    pkt_nxt;
    logic [7:0]       rx_next;
    logic             half_done;
    logic             in_flight;

    assign pkt_nxt   = pkt_sh << 8;
    assign rx_next   = mlb_r ? {rx_byte[6:0], miso} : {miso, rx_byte[7:1]};
    assign half_done = (cnt == cdiv_r);
    // DONE/ABORT are already winding down, so abort only acts on the shifting phases
    assign in_flight = (state == ST_SETUP) || (state == ST_SHIFT) ||
                       (state == ST_GAP)   || (state == ST_HOLD);

    // Packet sequencer: handshake, sck generation, tx/rx shifting and completion pulses
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= ST_IDLE;
            pkt_ready <= 1'b0;
            sck       <= 1'b0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            aborted   <= 1'b0;
            busy      <= 1'b0;
            pkt_sh    <= '0;
            tx_byte   <= '0;
            rx_byte   <= '0;
            cdiv_r    <= '0;
            mlb_r     <= 1'b1;
            cnt       <= '0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            gap_cnt   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            aborted   <= 1'b0;
            if (abort && in_flight) begin
                sck     <= 1'b0;
                cs_n    <= 1'b1;
                mosi    <= 1'b0;
                aborted <= 1'b1;
                state   <= ST_ABORT;
            end else begin
                case (state)
                    ST_IDLE: begin
                        pkt_ready <= 1'b1;
                        if (pkt_valid && pkt_ready) begin
                            pkt_sh    <= pkt_in;
                            tx_byte   <= pkt_in[PW-1 -: 8];
                            cdiv_r    <= cdiv;
                            mlb_r     <= mlb;
                            rx_byte   <= '0;
                            cnt       <= '0;
                            bit_cnt   <= '0;
                            byte_idx  <= '0;
                            cs_n      <= 1'b0;
                            busy      <= 1'b1;
                            pkt_ready <= 1'b0;
                            mosi      <= mlb ? pkt_in[PW-1] : pkt_in[PW-8];
                            state     <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        if (half_done) begin
                            cnt   <= '0;
                            state <= ST_SHIFT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (!half_done) begin
                            cnt <= cnt + 1'b1;
                        end else if (!sck) begin
                            cnt     <= '0;
                            sck     <= 1'b1;
                            rx_byte <= rx_next;
                        end else begin
                            cnt <= '0;
                            sck <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                for (int i = 0; i < PKT_BYTES; i++) begin
                                    if (byte_idx == BW'(i)) begin
                                        rsp_data[PW-8-8*i +: 8] <= rx_byte;
                                    end
                                end
                                if (byte_idx == LAST_BYTE) begin
                                    state <= ST_HOLD;
                                end else begin
                                    byte_idx <= byte_idx + 1'b1;
                                    pkt_sh   <= pkt_nxt;
                                    tx_byte  <= pkt_nxt[PW-1 -: 8];
                                    mosi     <= mlb_r ? pkt_nxt[PW-1] : pkt_nxt[PW-8];
                                    if (GAP_CYCLES > 0) begin
                                        gap_cnt <= '0;
                                        state   <= ST_GAP;
                                    end
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                tx_byte <= mlb_r ? (tx_byte << 1) : (tx_byte >> 1);
                                mosi    <= mlb_r ? tx_byte[6] : tx_byte[1];
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == LAST_GAP) begin
                            cnt   <= '0;
                            state <= ST_SHIFT;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (half_done) begin
                            cnt       <= '0;
                            cs_n      <= 1'b1;
                            mosi      <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_DONE, ST_ABORT: begin
                        busy      <= 1'b0;
                        pkt_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
